// File: rtl/kernel_pkg.sv
// Shared constants, FSM state type and set-count clamp for the kernel loader.
package kernel_pkg;

  localparam int TAPS     = 9;
  localparam int MAX_SETS = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only 14 nine-tap sets fit in a 128-word block.
  function automatic logic [3:0] clamp_sets(input logic [3:0] n);
    return (n > 4'(MAX_SETS)) ? 4'(MAX_SETS) : n;
  endfunction

endpackage

// File: rtl/kl_wrap_counter.sv
// Modulo-MODULO up-counter with enable, synchronous clear and a wrap flag.
module kl_wrap_counter #(
  parameter int MODULO = 9,
  parameter int W      = (MODULO > 1) ? $clog2(MODULO) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  // wrap marks the enabled step that returns the count to zero.
  assign wrap = en && (count == W'(MODULO - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/kernel_loader.sv
// Streams kernel coefficients into 32 one-hot-selected memory blocks,
// set by set, with every output registered.
module kernel_loader
  import kernel_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 128,
  parameter int NUM_BLOCKS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [3:0]                 num_sets,
  input  logic [WIDTH-1:0]           coef_in,
  input  logic                       coef_valid,
  output logic                       coef_ready,
  output logic [$clog2(HEIGHT)-1:0]  KERNEL_write_addr,
  output logic [WIDTH-1:0]           KERNEL_din,
  output logic [NUM_BLOCKS-1:0]      KERNEL_we,
  output logic                       busy,
  output logic                       done
);

  localparam int ADDR_W = $clog2(HEIGHT);
  localparam int TAP_W  = $clog2(TAPS);
  localparam int BLK_W  = $clog2(NUM_BLOCKS);
  localparam int SET_W  = $clog2(MAX_SETS);

  state_t              state, next_state;
  logic                accept, clr, last_beat;
  logic [TAP_W-1:0]    tap_cnt;
  logic [BLK_W-1:0]    blk_cnt;
  logic [SET_W-1:0]    set_cnt, last_set;
  logic                tap_wrap, blk_wrap, set_wrap_unused;
  logic [ADDR_W-1:0]   set_base;

  logic [NUM_BLOCKS-1:0] we_d;
  logic [ADDR_W-1:0]     addr_d;
  logic [WIDTH-1:0]      din_d;
  logic                  ready_d, busy_d, done_d;

  assign accept    = coef_valid && (state == LOAD);
  assign clr       = (state != LOAD);
  assign last_beat = blk_wrap && (set_cnt == last_set);

  kl_wrap_counter #(.MODULO(TAPS), .W(TAP_W)) u_tap_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(accept),
    .count(tap_cnt), .wrap(tap_wrap)
  );

  kl_wrap_counter #(.MODULO(NUM_BLOCKS), .W(BLK_W)) u_blk_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(tap_wrap),
    .count(blk_cnt), .wrap(blk_wrap)
  );

  kl_wrap_counter #(.MODULO(MAX_SETS), .W(SET_W)) u_set_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(blk_wrap),
    .count(set_cnt), .wrap(set_wrap_unused)
  );

  // Running 9*set address base, advanced by addition instead of a multiply.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      set_base <= '0;
    end else if (blk_wrap) begin
      set_base <= set_base + ADDR_W'(TAPS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_set <= '0;
    end else if (state == IDLE && start) begin
      last_set <= SET_W'(clamp_sets(num_sets) - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (num_sets != 4'd0) ? LOAD : DONE;
      LOAD: if (last_beat) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered below.
  always_comb begin
    we_d = '0;
    if (accept) we_d[blk_cnt] = 1'b1;
    addr_d  = accept ? (set_base + ADDR_W'(tap_cnt)) : KERNEL_write_addr;
    din_d   = accept ? coef_in : KERNEL_din;
    ready_d = (next_state == LOAD);
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      KERNEL_we         <= '0;
      KERNEL_write_addr <= '0;
      KERNEL_din        <= '0;
      coef_ready        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      KERNEL_we         <= we_d;
      KERNEL_write_addr <= addr_d;
      KERNEL_din        <= din_d;
      coef_ready        <= ready_d;
      busy              <= busy_d;
      done              <= done_d;
    end
  end

endmodule

// File: tb/tb_kernel_loader.sv
// Scoreboard bench for kernel_loader: the driver queues expected writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_kernel_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_sets = 4'd0;
  logic [15:0] coef_in = 16'd0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [6:0]  KERNEL_write_addr;
  logic [15:0] KERNEL_din;
  logic [31:0] KERNEL_we;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] we;
    logic [6:0]  addr;
    logic [15:0] din;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int writes = 0;
  int done_pulses = 0;
  int max_addr = 0;
  int high_writes = 0;
  logic [15:0] mem [32][128];

  kernel_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_sets(num_sets),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .KERNEL_write_addr(KERNEL_write_addr), .KERNEL_din(KERNEL_din),
    .KERNEL_we(KERNEL_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected write for beat i, derived independently by division.
  function automatic void push_expect(input int i, input int total);
    exp_t e;
    int s, b, k;
    s = i / 288;
    b = (i % 288) / 9;
    k = i % 9;
    e.we   = 32'd1 << b;
    e.addr = 7'(9 * s + k);
    e.din  = 16'(i);
    e.last = (i == total - 1);
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (done) done_pulses++;
    if (KERNEL_we != 32'd0) begin
      exp_t e;
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got we=%0h addr=%0d din=%0h expected no write",
                 KERNEL_we, KERNEL_write_addr, KERNEL_din);
      end else begin
        e = exp_q.pop_front();
        if (KERNEL_we !== e.we || KERNEL_write_addr !== e.addr ||
            KERNEL_din !== e.din || done !== e.last) begin
          errors++;
          $display("[TB] FAIL write: got we=%0h addr=%0d din=%0h done=%0b expected we=%0h addr=%0d din=%0h done=%0b",
                   KERNEL_we, KERNEL_write_addr, KERNEL_din, done, e.we, e.addr, e.din, e.last);
        end
      end
      for (int b = 0; b < 32; b++) begin
        if (KERNEL_we[b]) mem[b][KERNEL_write_addr] = KERNEL_din;
      end
      if (int'(KERNEL_write_addr) > max_addr) max_addr = int'(KERNEL_write_addr);
      if (KERNEL_write_addr >= 7'd126) high_writes++;
    end
  end

  // Drives one load; abort_at stops feeding before that beat, restart_at re-pulses start.
  task automatic apply_stimulus(input logic [3:0] n, input bit stall,
                                input int abort_at, input int restart_at);
    int total, i, cyc;
    bit acc;
    total = ((n > 4'd14) ? 14 : int'(n)) * 288;
    start = 1'b1;
    num_sets = n;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < total && i != abort_at && cyc < 3 * total + 20) begin
      start = (i == restart_at);
      if (i == restart_at) num_sets = 4'd3;
      coef_valid = !stall || (cyc % 2 == 0);
      coef_in = 16'(i);
      acc = coef_valid && coef_ready;
      @(posedge clk);
      if (acc) begin
        push_expect(i, total);
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    coef_valid = 1'b0;
    if (i != total && i != abort_at) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_timeout: got %0d beats expected %0d", i, total);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && (exp_q.size() != 0 || busy); c++) @(negedge clk);
    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_stats();
    writes = 0;
    done_pulses = 0;
    max_addr = 0;
    high_writes = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_we", 64'(KERNEL_we), 64'd0);
    check_output("reset_addr", 64'(KERNEL_write_addr), 64'd0);
    check_output("reset_din", 64'(KERNEL_din), 64'd0);
    check_output("reset_flags", {61'd0, coef_ready, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] one set, continuous valid");
    clear_stats();
    apply_stimulus(4'd1, 1'b0, -1, -1);
    drain();
    check_output("s1_writes", 64'(writes), 64'd288);
    check_output("s1_done", 64'(done_pulses), 64'd1);
    check_output("s1_b0_a0", 64'(mem[0][0]), 64'd0);
    check_output("s1_b0_a8", 64'(mem[0][8]), 64'd8);
    check_output("s1_b31_a0", 64'(mem[31][0]), 64'd279);
    check_output("s1_b31_a8", 64'(mem[31][8]), 64'd287);
    check_output("s1_idle", {62'd0, busy, coef_ready}, 64'd0);

    $display("[TB] two sets, valid every other cycle");
    clear_stats();
    apply_stimulus(4'd2, 1'b1, -1, -1);
    drain();
    check_output("s2_writes", 64'(writes), 64'd576);
    check_output("s2_done", 64'(done_pulses), 64'd1);
    check_output("s2_b5_a12", 64'(mem[5][12]), 64'd336);
    check_output("s2_max_addr", 64'(max_addr), 64'd17);

    $display("[TB] zero sets");
    clear_stats();
    start = 1'b1;
    num_sets = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check_output("s0_first", {60'd0, done, busy, coef_ready, |KERNEL_we}, 64'b1100);
    @(negedge clk);
    check_output("s0_second", {61'd0, done, busy, coef_ready}, 64'd0);
    check_output("s0_writes", 64'(writes), 64'd0);

    $display("[TB] fifteen sets clamped to fourteen");
    clear_stats();
    apply_stimulus(4'd15, 1'b0, -1, -1);
    drain();
    check_output("s14_writes", 64'(writes), 64'd4032);
    check_output("s14_done", 64'(done_pulses), 64'd1);
    check_output("s14_max_addr", 64'(max_addr), 64'd125);
    check_output("s14_high", 64'(high_writes), 64'd0);
    check_output("s14_b0_a117", 64'(mem[0][117]), 64'd3744);
    check_output("s14_b31_a125", 64'(mem[31][125]), 64'd4031);

    $display("[TB] reset after 100 beats, then fresh load");
    clear_stats();
    apply_stimulus(4'd1, 1'b0, 100, -1);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_we", 64'(KERNEL_we), 64'd0);
    check_output("abort_addr", 64'(KERNEL_write_addr), 64'd0);
    check_output("abort_din", 64'(KERNEL_din), 64'd0);
    check_output("abort_flags", {61'd0, coef_ready, busy, done}, 64'd0);
    rst = 1'b0;
    check_output("abort_writes", 64'(writes), 64'd100);
    check_output("abort_done", 64'(done_pulses), 64'd0);
    check_output("abort_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    clear_stats();
    apply_stimulus(4'd1, 1'b0, -1, -1);
    drain();
    check_output("reload_writes", 64'(writes), 64'd288);
    check_output("reload_done", 64'(done_pulses), 64'd1);

    $display("[TB] start pulsed mid-load");
    clear_stats();
    apply_stimulus(4'd1, 1'b0, -1, 150);
    drain();
    check_output("restart_writes", 64'(writes), 64'd288);
    check_output("restart_done", 64'(done_pulses), 64'd1);
    check_output("restart_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
